multicycle_ctrl_fsm: RTL and testbench

//  Parametrised multicycle control unit that replaces the fixed single-latency load/store controller.
//  - Fetches over a req/ready memory handshake, so RAM latency may vary.
//  - Latches the instruction into an internal IR, decodes it, and drives the regfile, PC, RAM and mux selects.
//  - Supports Bcond (PC+disp) and Jcond (PC<-reg), with the full condition table, a flag write strobe and a retired-instruction counter.

---
 rtl/multicycle_ctrl_fsm.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: fetches over a req/ready handshake, latches the instruction
// into IR, and sequences regfile, PC, RAM and writeback-mux controls per instruction class.
module multicycle_ctrl_fsm #(
    parameter  int DATA_W = 16,
    parameter  int NREGS  = 16,
    parameter  int CNT_W  = 16,
    localparam int REG_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic [4:0]        flags_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic              lsc_mux_selct,
    output logic [NREGS-1:0]  wEnable,
    output logic [7:0]        opcode,
    output logic [REG_W-1:0]  Rdest_select,
    output logic [REG_W-1:0]  Rsrc_select,
    output logic [7:0]        Imm_in,
    output logic              Imm_select,
    output logic              fsm_alu_mem_selct,
    output logic              flags_en,
    output logic              pc_en,
    output logic [1:0]        pc_mux_selct,
    output logic [7:0]        pc_add_k,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_STORE, S_LOAD, S_LOAD_WB, S_BRANCH, S_JUMP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_ir;
    logic [CNT_W-1:0]    r_retired;

    logic [3:0] w_top, w_ext, w_rd, w_rs;
    logic [7:0] w_opc;

    assign w_top = r_ir[15:12];
    assign w_ext = r_ir[7:4];
    assign w_rd  = r_ir[11:8];
    assign w_rs  = r_ir[3:0];
    assign w_opc = {w_top, w_ext};

    // Register indices at or beyond NREGS decode to an all-zero enable.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [3:0] idx);
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (int'(idx) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    // flags = {L,C,F,Z,N}
    function automatic logic cond_true(input logic [3:0] cc, input logic [4:0] f);
        logic l, c, ff, z, n;
        {l, c, ff, z, n} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return ff;
            4'h9: return !ff;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ADD/ADDU/ADDC/SUB/SUBC/CMP/MUL share the same code in the ext field (R-type)
    // and in the top field (immediate form).
    function automatic logic is_flag_op(input logic [3:0] code);
        return code inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE};
    endfunction

    always_comb begin
        // NOTE: every output and the next state get a default first, so no path
        // through the case below can leave one unassigned and infer a latch.
        w_next_state      = r_state;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        lsc_mux_selct     = 1'b0;
        wEnable           = '0;
        opcode            = '0;
        Rdest_select      = '0;
        Rsrc_select       = '0;
        Imm_in            = '0;
        Imm_select        = 1'b0;
        fsm_alu_mem_selct = 1'b0;
        flags_en          = 1'b0;
        pc_en             = 1'b0;
        pc_mux_selct      = 2'd0;
        pc_add_k          = '0;

        if (!reset) begin
            opcode       = w_opc;
            Rdest_select = REG_W'(w_rd);
            Rsrc_select  = REG_W'(w_rs);
            Imm_in       = r_ir[7:0];
            Imm_select   = (w_top != 4'h0) && (w_top != 4'h4);

            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) w_next_state = S_DECODE;
                end
                S_DECODE: begin
                    if (w_top == 4'hC)                        w_next_state = S_BRANCH;
                    else if (w_top == 4'h4 && w_ext == 4'h4) w_next_state = S_STORE;
                    else if (w_top == 4'h4 && w_ext == 4'h0) w_next_state = S_LOAD;
                    else if (w_top == 4'h4 && w_ext == 4'hC) w_next_state = S_JUMP;
                    else                                      w_next_state = S_EXEC;
                end
                S_EXEC: begin
                    pc_en = 1'b1;
                    if (!(w_opc == 8'h0B || w_top == 4'hB || w_opc == 8'h00))
                        wEnable = reg_onehot(w_rd);
                    flags_en     = (w_top == 4'h0) ? is_flag_op(w_ext) : is_flag_op(w_top);
                    w_next_state = S_FETCH;
                end
                S_STORE: begin
                    mem_req       = 1'b1;
                    mem_we        = 1'b1;
                    lsc_mux_selct = 1'b1;
                    if (mem_ready) begin
                        pc_en        = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end
                S_LOAD: begin
                    mem_req       = 1'b1;
                    lsc_mux_selct = 1'b1;
                    if (mem_ready) w_next_state = S_LOAD_WB;
                end
                S_LOAD_WB: begin
                    fsm_alu_mem_selct = 1'b1;
                    wEnable           = reg_onehot(w_rs);
                    pc_en             = 1'b1;
                    w_next_state      = S_FETCH;
                end
                S_BRANCH: begin
                    pc_en        = 1'b1;
                    pc_add_k     = r_ir[7:0];
                    pc_mux_selct = cond_true(w_rd, flags_in) ? 2'd1 : 2'd0;
                    w_next_state = S_FETCH;
                end
                S_JUMP: begin
                    pc_en        = 1'b1;
                    pc_mux_selct = cond_true(w_rd, flags_in) ? 2'd2 : 2'd0;
                    w_next_state = S_FETCH;
                end
                default: w_next_state = S_FETCH;
            endcase
        end
    end

    // NOTE: reset is sampled only on the clock edge; it aborts any pending access
    // by forcing FETCH, and pc_en is already gated off so retired cannot advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH && mem_ready) r_ir <= mem_rdata;
            if (pc_en) r_retired <= r_retired + 1'b1;
        end
    end

    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: an instruction-level model predicts every cycle's controls for two
// DUT instances (default sizing, and NREGS=8/CNT_W=2 for out-of-range regs and counter wrap).
module tb_multicycle_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [4:0]  flags_in;

    logic        a_req, a_we, a_lsc, a_isel, a_msel, a_fen, a_pen;
    logic [15:0] a_wen;
    logic [7:0]  a_opc, a_imm, a_padd;
    logic [3:0]  a_rd, a_rs;
    logic [1:0]  a_pmux;
    logic [15:0] a_ret;

    logic        b_req, b_we, b_lsc, b_isel, b_msel, b_fen, b_pen;
    logic [7:0]  b_wen;
    logic [7:0]  b_opc, b_imm, b_padd;
    logic [2:0]  b_rd, b_rs;
    logic [1:0]  b_pmux;
    logic [1:0]  b_ret;

    multicycle_ctrl_fsm #(.DATA_W(16), .NREGS(16), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .flags_in(flags_in), .mem_req(a_req), .mem_we(a_we), .lsc_mux_selct(a_lsc),
        .wEnable(a_wen), .opcode(a_opc), .Rdest_select(a_rd), .Rsrc_select(a_rs),
        .Imm_in(a_imm), .Imm_select(a_isel), .fsm_alu_mem_selct(a_msel),
        .flags_en(a_fen), .pc_en(a_pen), .pc_mux_selct(a_pmux), .pc_add_k(a_padd),
        .retired(a_ret));

    multicycle_ctrl_fsm #(.DATA_W(16), .NREGS(8), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .flags_in(flags_in), .mem_req(b_req), .mem_we(b_we), .lsc_mux_selct(b_lsc),
        .wEnable(b_wen), .opcode(b_opc), .Rdest_select(b_rd), .Rsrc_select(b_rs),
        .Imm_in(b_imm), .Imm_select(b_isel), .fsm_alu_mem_selct(b_msel),
        .flags_en(b_fen), .pc_en(b_pen), .pc_mux_selct(b_pmux), .pc_add_k(b_padd),
        .retired(b_ret));

    // Expected controls for the current cycle; wreg = register written, -1 for none.
    typedef struct {
        bit       req, we, lsc, msel, fen, pen;
        bit [1:0] pmux;
        bit [7:0] padd;
        int       wreg;
    } exp_t;

    exp_t        e;
    bit          exp_on = 1'b0;
    bit          m_rst;
    logic [15:0] m_ir;
    int          m_retired;

    int checks = 0;
    int failures = 0;

    int cyc_cnt, lsc_cnt, pen_cnt, we_cnt;
    logic [15:0] pe_wen;
    logic [1:0]  pe_pmux;
    logic [7:0]  pe_padd;
    logic        pe_isel, pe_fen, pe_we, pe_lsc, pe_msel;
    logic        s_req, s_lsc, s_pen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_model(input logic [3:0] cc, input logic [4:0] f);
        bit l, c, fl, z, n;
        l = f[4]; c = f[3]; fl = f[2]; z = f[1]; n = f[0];
        case (cc)
            4'h0: return z;          4'h1: return !z;
            4'h2: return c;          4'h3: return !c;
            4'h4: return l;          4'h5: return !l;
            4'h6: return n;          4'h7: return !n;
            4'h8: return fl;         4'h9: return !fl;
            4'hA: return !l && !z;   4'hB: return l || z;
            4'hC: return !n && !z;   4'hD: return n || z;
            4'hE: return 1'b1;       default: return 1'b0;
        endcase
    endfunction

    function automatic bit sets_flags(input logic [7:0] opc);
        logic [3:0] key;
        key = (opc[7:4] == 4'h0) ? opc[3:0] : opc[7:4];
        return key inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE};
    endfunction

    task automatic clr_exp();
        e.req = 0; e.we = 0; e.lsc = 0; e.msel = 0; e.fen = 0; e.pen = 0;
        e.pmux = 0; e.padd = 0; e.wreg = -1;
    endtask

    task automatic step();
        @(negedge clk);
        s_req = a_req; s_lsc = a_lsc; s_pen = a_pen;
        cyc_cnt++;
        if (a_lsc) lsc_cnt++;
        if (a_pen) pen_cnt++;
        if (a_we)  we_cnt++;
        if (e.pen) begin
            pe_wen = a_wen; pe_pmux = a_pmux; pe_padd = a_padd; pe_isel = a_isel;
            pe_fen = a_fen; pe_we = a_we; pe_lsc = a_lsc; pe_msel = a_msel;
        end
        @(posedge clk);
        #1;
    endtask

    // Cycle-by-cycle comparison against the model for both instances.
    always @(negedge clk) begin
        logic [15:0] ew_a;
        logic [7:0]  ew_b;
        logic        f_on;
        if (exp_on) begin
            f_on = !m_rst;
            ew_a = (e.wreg >= 0 && e.wreg < 16) ? 16'(1 << e.wreg) : 16'h0;
            ew_b = (e.wreg >= 0 && e.wreg < 8)  ? 8'(1 << e.wreg)  : 8'h0;
            check("mem_req",   32'(a_req),  32'(e.req));
            check("mem_we",    32'(a_we),   32'(e.we));
            check("lsc",       32'(a_lsc),  32'(e.lsc));
            check("mem_sel",   32'(a_msel), 32'(e.msel));
            check("flags_en",  32'(a_fen),  32'(e.fen));
            check("pc_en",     32'(a_pen),  32'(e.pen));
            check("pc_mux",    32'(a_pmux), 32'(e.pmux));
            check("pc_add_k",  32'(a_padd), 32'(e.padd));
            check("wEnable",   32'(a_wen),  32'(ew_a));
            check("opcode",    32'(a_opc),  f_on ? 32'({m_ir[15:12], m_ir[7:4]}) : 32'h0);
            check("Rdest",     32'(a_rd),   f_on ? 32'(m_ir[11:8]) : 32'h0);
            check("Rsrc",      32'(a_rs),   f_on ? 32'(m_ir[3:0])  : 32'h0);
            check("Imm_in",    32'(a_imm),  f_on ? 32'(m_ir[7:0])  : 32'h0);
            check("Imm_select", 32'(a_isel),
                  32'(f_on && m_ir[15:12] != 4'h0 && m_ir[15:12] != 4'h4));
            check("retired",   32'(a_ret),  32'(m_retired % 65536));
            check("b_wEnable", 32'(b_wen),  32'(ew_b));
            check("b_Rdest",   32'(b_rd),   f_on ? 32'(m_ir[10:8]) : 32'h0);
            check("b_pc_en",   32'(b_pen),  32'(e.pen));
            check("b_mem_req", 32'(b_req),  32'(e.req));
            check("b_retired", 32'(b_ret),  32'(m_retired % 4));
        end
    end

    task automatic fetch(input logic [15:0] ins, input int fw);
        for (int k = 0; k <= fw; k++) begin
            mem_ready = (k == fw);
            mem_rdata = (k == fw) ? ins : 16'($urandom);
            clr_exp(); e.req = 1;
            step();
        end
        m_ir = ins;
        mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
        clr_exp();
        step();
    endtask

    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                             input logic [4:0] fl);
        logic [3:0] top, ext, rd, rs;
        logic [7:0] opc;
        top = ins[15:12]; ext = ins[7:4]; rd = ins[11:8]; rs = ins[3:0];
        opc = {top, ext};
        cyc_cnt = 0; lsc_cnt = 0; pen_cnt = 0; we_cnt = 0;
        flags_in = fl;
        fetch(ins, fw);
        if (top == 4'h4 && ext == 4'h4) begin
            for (int k = 0; k <= mw; k++) begin
                mem_ready = (k == mw);
                clr_exp(); e.req = 1; e.we = 1; e.lsc = 1; e.pen = (k == mw);
                step();
            end
        end else if (top == 4'h4 && ext == 4'h0) begin
            for (int k = 0; k <= mw; k++) begin
                mem_ready = (k == mw); mem_rdata = 16'($urandom);
                clr_exp(); e.req = 1; e.lsc = 1;
                step();
            end
            mem_ready = 1'($urandom);
            clr_exp(); e.msel = 1; e.wreg = int'(rs); e.pen = 1;
            step();
        end else if (top == 4'h4 && ext == 4'hC) begin
            mem_ready = 1'($urandom);
            clr_exp(); e.pen = 1; e.pmux = cond_model(rd, fl) ? 2'd2 : 2'd0;
            step();
        end else if (top == 4'hC) begin
            mem_ready = 1'($urandom);
            clr_exp(); e.pen = 1; e.padd = ins[7:0];
            e.pmux = cond_model(rd, fl) ? 2'd1 : 2'd0;
            step();
        end else begin
            mem_ready = 1'($urandom);
            clr_exp(); e.pen = 1; e.fen = sets_flags(opc);
            e.wreg = (opc == 8'h0B || top == 4'hB || opc == 8'h00) ? -1 : int'(rd);
            step();
        end
        m_retired++;
    endtask

    initial begin
        logic [15:0] ins;
        reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0; flags_in = '0;
        m_rst = 1; m_ir = '0; m_retired = 0; clr_exp();
        step();
        exp_on = 1'b1;
        step();
        reset = 1'b0; m_rst = 0;

        // ADDI R3,#5 with ready high throughout
        run_instr(16'h5305, 0, 0, 5'h00);
        check("addi_latency", 32'(cyc_cnt), 32'd3);
        check("addi_wen", 32'(pe_wen), 32'h0008);
        check("addi_isel", 32'(pe_isel), 32'd1);
        check("addi_fen", 32'(pe_fen), 32'd1);
        check("addi_pen_once", 32'(pen_cnt), 32'd1);
        check("addi_retired", 32'(a_ret), 32'd1);

        // LOAD into R7 with ready held low 3 cycles
        run_instr(16'h4207, 0, 3, 5'h00);
        check("load_lsc_cycles", 32'(lsc_cnt), 32'd4);
        check("load_latency", 32'(cyc_cnt), 32'd7);
        check("load_wen", 32'(pe_wen), 32'h0080);
        check("load_msel", 32'(pe_msel), 32'd1);

        // STOR with ready high
        run_instr(16'h4245, 0, 0, 5'h00);
        check("store_latency", 32'(cyc_cnt), 32'd3);
        check("store_we_cycles", 32'(we_cnt), 32'd1);
        check("store_we_at_pen", 32'(pe_we), 32'd1);
        check("store_lsc_at_pen", 32'(pe_lsc), 32'd1);
        check("store_wen", 32'(pe_wen), 32'h0000);

        // Bcond EQ disp=-4, taken then not taken, and the never-taken code
        run_instr(16'hC0FC, 0, 0, 5'b00010);
        check("beq_taken_mux", 32'(pe_pmux), 32'd1);
        check("beq_disp", 32'(pe_padd), 32'hFC);
        run_instr(16'hC0FC, 1, 0, 5'b11101);
        check("beq_not_taken_mux", 32'(pe_pmux), 32'd0);
        run_instr(16'hCF10, 0, 0, 5'b11111);
        check("b_never_mux", 32'(pe_pmux), 32'd0);

        // Jcond UC R9, then CMP R1,R2 (no write, flags updated)
        run_instr(16'h4EC9, 0, 0, 5'h00);
        check("juc_mux", 32'(pe_pmux), 32'd2);
        check("jump_latency", 32'(cyc_cnt), 32'd3);
        run_instr(16'h01B2, 2, 0, 5'h00);
        check("cmp_wen", 32'(pe_wen), 32'h0000);
        check("cmp_fen", 32'(pe_fen), 32'd1);

        // Reset while LOAD is waiting on mem_ready
        pen_cnt = 0;
        fetch(16'h4207, 0);
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'b0; clr_exp(); e.req = 1; e.lsc = 1; step();
        end
        reset = 1'b1; m_rst = 1; mem_ready = 1'b1; clr_exp();
        step();
        check("rst_mid_req", 32'(s_req), 32'd0);
        check("rst_mid_lsc", 32'(s_lsc), 32'd0);
        check("rst_mid_no_pen", 32'(pen_cnt), 32'd0);
        reset = 1'b0; m_rst = 0; m_ir = '0; m_retired = 0;
        check("rst_retired_zero", 32'(a_ret), 32'd0);

        // Four instructions after reset: narrow counter wraps to 0
        run_instr(16'h5305, 0, 0, 5'h00);
        run_instr(16'h4245, 0, 1, 5'h00);
        run_instr(16'h4EC9, 1, 0, 5'h00);
        run_instr(16'h0153, 0, 0, 5'h00);
        check("wrap_b_retired", 32'(b_ret), 32'd0);
        check("wrap_a_retired", 32'(a_ret), 32'd4);

        // Randomised instruction mix, wait states and flags
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: ins = {4'h4, 4'($urandom), 4'h4, 4'($urandom)};
                1: ins = {4'h4, 4'($urandom), 4'h0, 4'($urandom)};
                2: ins = {4'h4, 4'($urandom), 4'hC, 4'($urandom)};
                3: ins = {4'hC, 12'($urandom)};
                4: ins = {4'h0, 12'($urandom)};
                default: ins = 16'($urandom);
            endcase
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 5'($urandom));
        end

        exp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
